mips_uart_rx: RTL and testbench
===============================

# mips_uart_rx

Serial receiver feeding the debug unit's command and program-load path. Oversamples the idle-high RX line at 16x using an internal baud-tick generator, deserialises 8N1 frames LSB-first, and presents each byte with a level `o_rx_ready` flag. The flag is held until the debug unit clears it with `i_rx_reset`. It sits between the board RX pin and the debug unit's `i_uart_rx_ready` / `i_uart_rx_data` / `o_uart_rx_reset` ports.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame.
- `BAUD_DIV`, 163: clk cycles per oversample tick (50 MHz / (19200 × 16)); must be ≥ 2.
- `OVERSAMPLE`, 16: ticks per bit; must be even.

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `reset`, input, 1: synchronous, active-high.
- `i_rx`, input, 1: asynchronous serial line, idle high.
- `i_rx_reset`, input, 1: level clear of `o_rx_ready`, `o_frame_err` and `o_overrun`; driven by the debug unit.
- `o_rx_ready`, output, 1: a valid byte is held in `o_rx_data`.
- `o_rx_data`, output, `DATA_BITS`: last good byte, LSB received first.
- `o_frame_err`, output, 1: sticky; a stop bit was sampled low.
- `o_overrun`, output, 1: sticky; a byte completed while `o_rx_ready` was already set.

## Operation
- `i_rx` passes through a 2-flop synchroniser; both flops reset to 1. All FSM decisions use the synchronised value `rx_s`.
- Tick generator: free-running counter 0..`BAUD_DIV`-1. `tick` is high for one clk when the counter reaches `BAUD_DIV`-1, then the counter wraps to 0. It is never restarted by the FSM.
- Per-state tick counter `s`, width clog2(`OVERSAMPLE`). Bit counter `n`, width clog2(`DATA_BITS`)+1. Shift register `sh`, `DATA_BITS` wide.
- FSM states:
  - IDLE: on `rx_s`==0, go to START with `s`=0. No tick is required for this transition.
  - START: on each tick, `s`++. At `s`==`OVERSAMPLE`/2-1 on a tick: if `rx_s`==0, go to DATA with `s`=0, `n`=0; else return to IDLE (glitch rejection).
  - DATA: on each tick, `s`++. At `s`==`OVERSAMPLE`-1 on a tick: `sh` <= {`rx_s`, `sh`[`DATA_BITS`-1:1]}, `s`=0, `n`++. After the `DATA_BITS`-th sample, go to STOP.
  - STOP: at `s`==`OVERSAMPLE`-1 on a tick, sample `rx_s` and go to IDLE.
    - If `rx_s`==1: `o_rx_data` <= `sh`, `o_rx_ready` <= 1. If `o_rx_ready` was already 1, also `o_overrun` <= 1.
    - If `rx_s`==0: `o_frame_err` <= 1; `o_rx_data` and `o_rx_ready` are unchanged.
- Clear rule: while `i_rx_reset`==1, `o_rx_ready`, `o_frame_err` and `o_overrun` are driven to 0 the next clk. A completion event in the same cycle wins: the flags it sets are set, `o_rx_data` loads, and the others clear.
- `i_rx_reset` never affects the FSM, counters or `sh`; reception continues during a clear.

## Timing
- Reset values:
  - `o_rx_ready`=0, `o_rx_data`=0, `o_frame_err`=0, `o_overrun`=0.
  - FSM=IDLE, `s`=`n`=0, tick counter=0, `sh`=0, synchroniser=11.
- Reset mid-frame aborts the frame with no output change beyond the reset values. The next start bit is detected normally.
- Input latency: 2 clk from `i_rx` to `rx_s`.
- Sample points are mid-bit ±1 tick, because tick phase is free-running.
- `o_rx_ready` rises 1 clk after the stop-sample tick. Nominal frame-to-ready time ≈ (0.5 + `DATA_BITS` + 1) × `OVERSAMPLE` × `BAUD_DIV` clk, +2 for the synchroniser.
- Handshake with the debug unit: ready holds until the clear; the debug unit holds `i_rx_reset` high for ≥1 clk after seeing ready. At most one byte completes per frame time, so no double consumption.
- Back-to-back frames: the falling edge of the next start bit is accepted as soon as STOP returns to IDLE.

## Structure
- Shared package `mips_uart_pkg`: FSM state localparams (IDLE/START/DATA/STOP, 2-bit), default `BAUD_DIV`/`OVERSAMPLE`/`DATA_BITS`. The matching TX uses the same package.
- Sub-module `mips_uart_baud_gen` (params `BAUD_DIV`; ports `clk`, `reset`, `o_tick`), shared with the TX block.
- Registered outputs only; next-state logic in a single combinational block.

## Test plan
All scenarios use `BAUD_DIV`=4, `OVERSAMPLE`=16, so 64 clk per bit.
- Send 0x72 ('r') with a good stop bit -> `o_rx_data`=0x72, `o_rx_ready`=1 within 610±8 clk of the start edge. Ready holds indefinitely until `i_rx_reset`=1 for 1 clk, then drops the next clk.
- Low glitch of 20 clk on idle line -> FSM returns to IDLE; no ready, no error. Then send 0x6C -> `o_rx_data`=0x6C.
- Send 0x73 with stop bit forced 0 -> `o_frame_err`=1, `o_rx_ready`=0, `o_rx_data` keeps its previous value. `i_rx_reset` clears `o_frame_err`.
- Send 0x6E then 0xFF with no clear in between -> `o_rx_data`=0xFF, `o_rx_ready`=1, `o_overrun`=1.
- Assert `i_rx_reset` on the exact clk that 0x11 completes -> `o_rx_ready`=1, `o_rx_data`=0x11 (completion wins).
- Assert `reset` during bit 4 of 0xAA, release, send 0x55 -> outputs at reset values until 0x55 completes; then `o_rx_data`=0x55, no error flags.

Source files
------------

// File: rtl/mips_uart_pkg.sv
// Shared definitions for the debug-unit UART: receiver FSM states and default
// frame/baud parameters, common to the RX and TX blocks.
package mips_uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int BAUD_DIV_DEF   = 163;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mips_uart_baud_gen.sv
// Free-running oversample tick generator: one-clk pulse every BAUD_DIV cycles.
// Never resynchronised to the line, so sample phase jitters by up to one tick.
module mips_uart_baud_gen
  import mips_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  assign o_tick = (cnt_reg == LAST);

  always_comb begin
    cnt_next = o_tick ? '0 : cnt_reg + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/mips_uart_rx.sv
// 8N1 serial receiver for the debug unit: 16x oversampled, LSB first, with a
// level ready flag held until the debug unit clears it, plus sticky error flags.
module mips_uart_rx
  import mips_uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx,
  input  logic                 i_rx_reset,
  output logic                 o_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS) + 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic tick;
  logic rx_s;
  logic [1:0] sync_reg;

  uart_state_t          state_reg, state_next;
  logic [SW-1:0]        s_reg, s_next;
  logic [NW-1:0]        n_reg, n_next;
  logic [DATA_BITS-1:0] sh_reg, sh_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 ready_reg, ready_next;
  logic                 err_reg, err_next;
  logic                 ovr_reg, ovr_next;

  mips_uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  // Two-stage synchroniser; idles high so reset never looks like a start bit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset)        sync_reg[gi] <= 1'b1;
        else if (gi == 0) sync_reg[gi] <= i_rx;
        else              sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign rx_s = sync_reg[1];

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    sh_next    = sh_reg;
    data_next  = data_reg;
    // Clear request drops the flags unless a completion below re-sets them.
    ready_next = ready_reg & ~i_rx_reset;
    err_next   = err_reg & ~i_rx_reset;
    ovr_next   = ovr_reg & ~i_rx_reset;

    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          s_next     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_reg == S_HALF) begin
            s_next     = '0;
            n_next     = '0;
            state_next = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_reg == S_LAST) begin
            sh_next = {rx_s, sh_reg[DATA_BITS-1:1]};
            s_next  = '0;
            n_next  = n_reg + NW'(1);
            if (n_reg == N_LAST) state_next = ST_STOP;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s_reg == S_LAST) begin
            state_next = ST_IDLE;
            s_next     = '0;
            if (rx_s) begin
              data_next  = sh_reg;
              ready_next = 1'b1;
              if (ready_reg) ovr_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      sh_reg    <= '0;
      data_reg  <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      sh_reg    <= sh_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      err_reg   <= err_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign o_rx_ready  = ready_reg;
  assign o_rx_data   = data_reg;
  assign o_frame_err = err_reg;
  assign o_overrun   = ovr_reg;

endmodule

// File: tb/tb_mips_uart_rx.sv
// Directed + randomised bench for mips_uart_rx with a frame-level reference
// model and exact prediction of the ready edge from the free-running tick phase.
module tb_mips_uart_rx;

  localparam int DB   = 8;
  localparam int BAUD = 4;
  localparam int OS   = 16;
  localparam int BIT  = BAUD * OS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_rx = 1'b1;
  logic          i_rx_reset = 1'b0;
  logic          o_rx_ready;
  logic [DB-1:0] o_rx_data;
  logic          o_frame_err;
  logic          o_overrun;

  mips_uart_rx #(.DATA_BITS(DB), .BAUD_DIV(BAUD), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (i_rx),
    .i_rx_reset  (i_rx_reset),
    .o_rx_ready  (o_rx_ready),
    .o_rx_data   (o_rx_data),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Edge bookkeeping: ecnt = index of the latest posedge, k0 = last reset edge.
  int ecnt = 0;
  int k0   = 0;
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (reset) k0 <= ecnt + 1;
  end

  int   last_rise = 0;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (o_rx_ready && !prev_ready) last_rise = ecnt;
    prev_ready = o_rx_ready;
  end

  // Reference model of the user-visible outputs.
  logic          m_ready, m_err, m_ovr;
  logic [DB-1:0] m_data;
  int            e_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(o_rx_ready), 32'(m_ready));
    chk({tag, "_data"},  32'(o_rx_data),  32'(m_data));
    chk({tag, "_ferr"},  32'(o_frame_err), 32'(m_err));
    chk({tag, "_ovr"},   32'(o_overrun),  32'(m_ovr));
  endtask

  task automatic model_reset();
    m_ready = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_data = '0;
  endtask

  task automatic model_frame(input logic [DB-1:0] b, input bit good);
    if (good) begin
      if (m_ready) m_ovr = 1'b1;
      m_ready = 1'b1;
      m_data  = b;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Stop-sample edge: first tick consumed after the FSM leaves IDLE, plus
  // half a start bit, DB data bits and one stop bit worth of ticks.
  function automatic int predict_done(input int e);
    int first_tick;
    first_tick = e + 4 + (((k0 - e - 4) % BAUD) + BAUD) % BAUD;
    return first_tick + (OS / 2 + DB * OS + OS - 1) * BAUD;
  endfunction

  // Sends one frame; a bad stop bit is held low only long enough to be sampled.
  task automatic send_frame(input logic [DB-1:0] b, input bit stop);
    @(posedge clk); #1;
    e_last = ecnt;
    i_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < DB; i++) begin
      i_rx = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    if (stop) begin
      i_rx = 1'b1;
      repeat (BIT) @(posedge clk);
    end else begin
      i_rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      i_rx = 1'b1;
      repeat (BIT - 40) @(posedge clk);
    end
    #1;
    repeat (100) @(posedge clk);
    #1;
    $display("frame data=%02h stop=%0d ready=%0b data_out=%02h ferr=%0b ovr=%0b",
             b, stop, o_rx_ready, o_rx_data, o_frame_err, o_overrun);
  endtask

  task automatic clear_flags();
    @(posedge clk); #1;
    i_rx_reset = 1'b1;
    @(posedge clk); #1;
    i_rx_reset = 1'b0;
    m_ready = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
  endtask

  initial begin
    logic [DB-1:0] rb;
    bit            rgood;
    bit            was_ready;
    int            ts;
    int            lat;

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_all("reset");

    // Good frame, exact and nominal latency, hold, then clear.
    last_rise = 0;
    send_frame(8'h72, 1'b1);
    model_frame(8'h72, 1'b1);
    ts  = predict_done(e_last);
    lat = last_rise - e_last;
    chk("r_rise_edge", 32'(last_rise), 32'(ts));
    chk("r_latency_window", 32'(lat >= 602 && lat <= 618), 32'd1);
    chk_all("r_frame");
    repeat (500) @(posedge clk);
    chk_all("r_hold");
    clear_flags();
    chk_all("r_clear");

    // Start-bit glitch rejection, then a normal frame.
    @(posedge clk); #1 i_rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (100) @(posedge clk);
    chk_all("glitch");
    send_frame(8'h6C, 1'b1);
    model_frame(8'h6C, 1'b1);
    chk_all("l_frame");
    clear_flags();

    // Framing error keeps previous data, clear drops the error.
    send_frame(8'h73, 1'b0);
    model_frame(8'h73, 1'b0);
    chk_all("ferr");
    clear_flags();
    chk_all("ferr_clr");

    // Overrun: two frames without a clear.
    send_frame(8'h6E, 1'b1);
    model_frame(8'h6E, 1'b1);
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    chk_all("overrun");
    clear_flags();

    // Clear asserted on exactly the completion cycle: completion wins.
    fork
      send_frame(8'h11, 1'b1);
      begin
        @(posedge clk); #2;
        ts = predict_done(e_last);
        while (ecnt < ts - 1) begin
          @(posedge clk); #1;
        end
        i_rx_reset = 1'b1;
        @(posedge clk); #1;
        i_rx_reset = 1'b0;
      end
    join
    model_frame(8'h11, 1'b1);
    chk_all("cwin");
    clear_flags();

    // Random frames against the model, with random clears.
    for (int k = 0; k < 8; k++) begin
      rb        = 8'($urandom);
      rgood     = ($urandom_range(0, 3) != 0);
      was_ready = m_ready;
      last_rise = 0;
      send_frame(rb, rgood);
      model_frame(rb, rgood);
      if (rgood && !was_ready)
        chk("rnd_rise_edge", 32'(last_rise), 32'(predict_done(e_last)));
      chk_all("rnd");
      if ($urandom_range(0, 1) == 1) begin
        clear_flags();
        chk_all("rnd_clr");
      end
    end

    // Reset partway through bit 4 of 0xAA; the sender abandons the frame.
    @(posedge clk); #1 i_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      i_rx = (i % 2 == 1);
      repeat (BIT) @(posedge clk);
      #1;
    end
    i_rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    i_rx  = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk_all("rst_mid");
    repeat (300) @(posedge clk);
    chk_all("rst_idle");
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    chk_all("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
